// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding and frame constants.
package serial_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 50;
  localparam int DATA_BITS           = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK,
    PARITY = ST_PARITY
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/serial_rx_framer.sv
// UART receiver (8N1, or 8E1 when SERIAL_RX_PARITY_EN is defined) with glitch rejection,
// framing-error strobe and line-break indication.
module serial_rx_framer
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       line_break
);

  localparam int CTR_W = $clog2(CLK_PER_BIT);
  localparam logic [CTR_W-1:0] HALF_CNT = CTR_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(CLK_PER_BIT - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state, state_d;
  logic [CTR_W-1:0]     ctr, ctr_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [7:0]           data_d;
  logic                 strobe_d, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_bit, par_d;
  logic                 perr_d;
`endif

  always_comb begin
    state_d   = state;
    ctr_d     = ctr + CTR_W'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    data_d    = rx_data;
    strobe_d  = 1'b0;
    ferr_d    = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d     = par_bit;
    perr_d    = 1'b0;
`endif
    case (state)
      IDLE: begin
        ctr_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid start bit: a line that is already high again was only a glitch.
        if (ctr == HALF_CNT) begin
          ctr_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (ctr == LAST_CNT) begin
          ctr_d            = '0;
          shift_d[bit_idx] = rx_s;
          bit_idx_d        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (ctr == LAST_CNT) begin
          ctr_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
        if (ctr == LAST_CNT) begin
          ctr_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if ((^shift) ^ par_bit) begin
              perr_d = 1'b1;
            end else begin
              data_d   = shift;
              strobe_d = 1'b1;
            end
`else
            data_d   = shift;
            strobe_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        ctr_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        ctr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctr         <= '0;
      bit_idx     <= '0;
      rx_data     <= '0;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      ctr         <= ctr_d;
      bit_idx     <= bit_idx_d;
      rx_data     <= data_d;
      new_rx_data <= strobe_d;
      frame_err   <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      parity_err  <= perr_d;
`endif
    end
  end

  // Shift register contents are only consumed after a full frame, so no reset is needed.
  always_ff @(posedge clk) begin
    shift <= shift_d;
`ifdef SERIAL_RX_PARITY_EN
    par_bit <= par_d;
`endif
  end

  assign line_break = (state == BREAK);

endmodule

// File: tb/tb_serial_rx_framer.sv
// Directed bench for serial_rx_framer: table of back-to-back frames plus glitch, break,
// mid-frame reset and (with SERIAL_RX_PARITY_EN) parity sequences.
module tb_serial_rx_framer;

  localparam int CPB = 50;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME = CPB * 11;
`else
  localparam int FRAME = CPB * 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       frame_err;
  logic       line_break;
`ifdef SERIAL_RX_PARITY_EN
  logic       parity_err;
`endif

  serial_rx_framer #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .frame_err   (frame_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .line_break  (line_break)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_strobe = 0, n_ferr = 0, n_perr = 0, n_both = 0;
  int last_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (new_rx_data) begin
        n_strobe = n_strobe + 1;
        last_cyc = cyc;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (new_rx_data && frame_err) n_both = n_both + 1;
`ifdef SERIAL_RX_PARITY_EN
      if (parity_err) n_perr = n_perr + 1;
      if (parity_err && (new_rx_data || frame_err)) n_both = n_both + 1;
`endif
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^d) ^ par_bad);
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    int         exp_strobes;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int s0, f0, p0, prev_cyc, d;
    vecs[0] = '{8'hA5, 1, 8'hA5};
    vecs[1] = '{8'h00, 1, 8'h00};
    vecs[2] = '{8'hFF, 1, 8'hFF};
    vecs[3] = '{8'h3C, 1, 8'h3C};

    repeat (5) @(negedge clk);
    check("reset rx_data", int'(rx_data), 0);
    check("reset new_rx_data", int'(new_rx_data), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset line_break", int'(line_break), 0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // Table: frames sent back-to-back with no idle gap.
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      s0 = n_strobe;
      f0 = n_ferr;
      send_frame(vecs[i].data, 1'b1, 1'b0);
      check($sformatf("vec%0d strobes", i), n_strobe - s0, vecs[i].exp_strobes);
      check($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d frame_err", i), n_ferr - f0, 0);
      if (i > 0) begin
        d = last_cyc - prev_cyc;
        check($sformatf("vec%0d spacing", i), (d >= FRAME - 1 && d <= FRAME + 1) ? FRAME : d, FRAME);
      end
      prev_cyc = last_cyc;
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);

    // Short low glitch must be rejected and leave the receiver ready for a real frame.
    s0 = n_strobe;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch no strobe", n_strobe - s0, 0);
    check("glitch line_break", int'(line_break), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post-glitch strobes", n_strobe - s0, 1);
    check("post-glitch rx_data", int'(rx_data), 8'h5A);
    repeat (CPB) @(negedge clk);

    // Framing error followed by a held-low line.
    s0 = n_strobe;
    f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("break frame_err pulses", n_ferr - f0, 1);
    check("break line_break high", int'(line_break), 1);
    check("break no strobe", n_strobe - s0, 0);
    check("break rx_data kept", int'(rx_data), 8'h5A);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break line_break released", int'(line_break), 0);
    repeat (CPB) @(negedge clk);

    // Reset during bit 4 of 0x81, then a clean 0x81.
    s0 = n_strobe;
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    check("abort no strobe", n_strobe - s0, 0);
    check("abort no frame_err", n_ferr - f0, 0);
    check("abort rx_data cleared", int'(rx_data), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    check("after abort strobes", n_strobe - s0, 1);
    check("after abort rx_data", int'(rx_data), 8'h81);
    repeat (CPB) @(negedge clk);

`ifdef SERIAL_RX_PARITY_EN
    s0 = n_strobe;
    p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    check("bad parity parity_err", n_perr - p0, 1);
    check("bad parity no strobe", n_strobe - s0, 0);
    check("bad parity rx_data kept", int'(rx_data), 8'h81);
    repeat (CPB) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b0);
    check("good parity strobe", n_strobe - s0, 1);
    check("good parity rx_data", int'(rx_data), 8'h07);
    check("good parity no parity_err", n_perr - p0, 1);
    repeat (CPB) @(negedge clk);
`else
    p0 = n_perr;
    check("no parity events", n_perr - p0, 0);
`endif

    check("strobes exclusive", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
